// File: rtl/striping_pkg.sv
// Shared definitions for the two-lane striper and its un-striping partner.
// The lane-select encoding must match on both sides of the lanes.
package striping_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    // Selector FSM states; the value doubles as the target lane index.
    localparam logic [0:0] LANE0 = 1'b0;
    localparam logic [0:0] LANE1 = 1'b1;

    function automatic logic [0:0] next_lane(input logic [0:0] cur);
        return (cur == LANE0) ? LANE1 : LANE0;
    endfunction

endpackage

// File: rtl/striping_lane_reg.sv
// One lane output register: captures a word on load and flags it valid
// for exactly that cycle; otherwise the word is held and valid drops.
module striping_lane_reg
    import striping_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk_2f,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  valid
);

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end else begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/striping.sv
// Transmit-side word striper: alternates valid input words between lane 0
// and lane 1, starting on lane 0 after reset, with one cycle of latency.
module striping
    import striping_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk_2f,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] lane_0,
    output logic [DATA_WIDTH-1:0] lane_1,
    output logic                  valid_0,
    output logic                  valid_1
);

    // Handshake: valid-only, no backpressure. A word is consumed on every
    // rising edge where valid_in=1 and reset=0; valid_0/valid_1 pulse for
    // one cycle when the matching lane register holds a fresh word.

    logic [0:0] sel;
    logic [0:0] sel_next;
    logic       load_0;
    logic       load_1;

    // Bubbles hold the selector so lane order survives gaps in valid_in.
    always_comb begin
        sel_next = sel;
        if (valid_in) begin
            sel_next = next_lane(sel);
        end
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            sel <= LANE0;
        end else begin
            sel <= sel_next;
        end
    end

    assign load_0 = valid_in & (sel == LANE0);
    assign load_1 = valid_in & (sel == LANE1);

    striping_lane_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lane_0 (
        .clk_2f (clk_2f),
        .reset  (reset),
        .load   (load_0),
        .d      (data_in),
        .q      (lane_0),
        .valid  (valid_0)
    );

    striping_lane_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lane_1 (
        .clk_2f (clk_2f),
        .reset  (reset),
        .load   (load_1),
        .d      (data_in),
        .q      (lane_1),
        .valid  (valid_1)
    );

endmodule

// File: tb/tb_striping.sv
// Bench for the two-lane striper: directed vector table, then random
// traffic with gaps and resets against a word-count reference model.
module tb_striping;

    localparam int W = 32;

    logic         clk_2f;
    logic         reset;
    logic [W-1:0] data_in;
    logic         valid_in;
    logic [W-1:0] lane_0;
    logic [W-1:0] lane_1;
    logic         valid_0;
    logic         valid_1;

    int checks;
    int errors;

    // Reference model: lane chosen by how many words were accepted since reset.
    logic [W-1:0] m_l0, m_l1;
    logic         m_v0, m_v1;
    int           m_count;

    typedef struct {
        logic         rst;
        logic         vld;
        logic [W-1:0] din;
        logic [W-1:0] e_l0;
        logic [W-1:0] e_l1;
        logic         e_v0;
        logic         e_v1;
    } vec_t;

    vec_t vecs[16];

    striping #(.DATA_WIDTH(W)) dut (
        .clk_2f   (clk_2f),
        .reset    (reset),
        .data_in  (data_in),
        .valid_in (valid_in),
        .lane_0   (lane_0),
        .lane_1   (lane_1),
        .valid_0  (valid_0),
        .valid_1  (valid_1)
    );

    initial clk_2f = 1'b0;
    always #5 clk_2f = ~clk_2f;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic vld, input logic [W-1:0] d);
        if (rst) begin
            m_l0 = '0; m_l1 = '0; m_v0 = 1'b0; m_v1 = 1'b0; m_count = 0;
        end else if (vld) begin
            if (m_count % 2 == 0) begin
                m_l0 = d; m_v0 = 1'b1; m_v1 = 1'b0;
            end else begin
                m_l1 = d; m_v1 = 1'b1; m_v0 = 1'b0;
            end
            m_count++;
        end else begin
            m_v0 = 1'b0; m_v1 = 1'b0;
        end
    endtask

    // Drive at the falling edge, clock, then compare 1 time unit after the rising edge.
    task automatic cycle(input logic rst, input logic vld, input logic [W-1:0] d);
        @(negedge clk_2f);
        reset    = rst;
        valid_in = vld;
        data_in  = d;
        @(posedge clk_2f);
        #1;
        model_step(rst, vld, d);
        check("model_lane_0", lane_0, m_l0);
        check("model_lane_1", lane_1, m_l1);
        check("model_valid_0", {31'b0, valid_0}, {31'b0, m_v0});
        check("model_valid_1", {31'b0, valid_1}, {31'b0, m_v1});
        check("never_both_valid", {31'b0, valid_0 & valid_1}, '0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1; valid_in = 1'b0; data_in = '0;
        m_l0 = '0; m_l1 = '0; m_v0 = 1'b0; m_v1 = 1'b0; m_count = 0;

        //          rst   vld   din            lane_0         lane_1         v0    v1
        vecs[0]  = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'h0,         32'h0,         1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'h0,         32'h0,         1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'hAAAA0001, 32'hAAAA0001,  32'h0,         1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'hAAAA0002, 32'hAAAA0001,  32'hAAAA0002,  1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 32'hAAAA0003, 32'hAAAA0003,  32'hAAAA0002,  1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'hAAAA0004, 32'hAAAA0003,  32'hAAAA0004,  1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 32'h11,       32'h11,        32'hAAAA0004,  1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 32'hDEADBEEF, 32'h11,        32'hAAAA0004,  1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 32'hDEADBEEF, 32'h11,        32'hAAAA0004,  1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h12345678, 32'h11,        32'hAAAA0004,  1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'h22,       32'h11,        32'h22,        1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 32'h5,        32'h5,         32'h22,        1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 32'h99,       32'h0,         32'h0,         1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'h6,        32'h6,         32'h0,         1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 32'h7,        32'h6,         32'h0,         1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 32'h8,        32'h6,         32'h8,         1'b0, 1'b1};

        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].rst, vecs[i].vld, vecs[i].din);
            check($sformatf("vec%0d_lane_0", i), lane_0, vecs[i].e_l0);
            check($sformatf("vec%0d_lane_1", i), lane_1, vecs[i].e_l1);
            check($sformatf("vec%0d_valid_0", i), {31'b0, valid_0}, {31'b0, vecs[i].e_v0});
            check($sformatf("vec%0d_valid_1", i), {31'b0, valid_1}, {31'b0, vecs[i].e_v1});
        end

        // Odd-length stream then reset: the partial pair is dropped and lane 0 restarts.
        cycle(1'b0, 1'b1, 32'hC0DE0001);
        cycle(1'b0, 1'b1, 32'hC0DE0002);
        cycle(1'b0, 1'b1, 32'hC0DE0003);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'hC0DE0004);
        check("post_reset_lane_0", lane_0, 32'hC0DE0004);
        check("post_reset_valid_0", {31'b0, valid_0}, 32'h1);
        check("post_reset_lane_1", lane_1, 32'h0);

        // Random traffic with gaps and occasional resets.
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0), W'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
